// File: rtl/audio_output_serializer_pkg.sv
// audio_output_serializer_pkg: shared widths, I2S framing constants and Q16.16 to PCM saturation
package audio_output_serializer_pkg;
  localparam int c_datawidth = 32;
  localparam int c_pcmwidth = 16;
  localparam int c_i2sslots = 32;
  function automatic logic [c_pcmwidth-1:0] saturate_to_pcm(input logic signed [c_datawidth-1:0] s);
    logic signed [c_datawidth-1:0] h;
    h = s >>> 1;
    return h > 32767 ? 16'h7fff : h < -32768 ? 16'h8000 : h[c_pcmwidth-1:0];
  endfunction
endpackage

// File: rtl/audio_output_serializer_if.sv
// audio_output_serializer_if: sample stream in, I2S lines, sticky flags and FIFO level out
interface audio_output_serializer_if import audio_output_serializer_pkg::*; #(
  parameter int FIFO_DEPTH = 8
);
  logic sample_valid;
  logic [c_datawidth-1:0] sample;
  logic clear_flags;
  logic bclk;
  logic lrclk;
  logic sdata;
  logic overflow;
  logic underflow;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  modport master (output sample_valid, sample, clear_flags, input bclk, lrclk, sdata, overflow, underflow, fifo_level);
  modport slave (input sample_valid, sample, clear_flags, output bclk, lrclk, sdata, overflow, underflow, fifo_level);
endinterface

// File: rtl/audio_output_serializer_sample_fifo.sv
// audio_output_serializer_sample_fifo: synchronous FIFO with push/pop, full/empty and registered level
module audio_output_serializer_sample_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] level_q;
  assign data_o = mem_q[rd_q];
  assign full_o = level_q == (AW+1)'(DEPTH);
  assign empty_o = level_q == '0;
  assign level_o = level_q;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q <= wr_q + 1'b1;
      end
      if (pop_i) rd_q <= rd_q + 1'b1;
      level_q <= level_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end
endmodule

// File: rtl/audio_output_serializer.sv
// audio_output_serializer: buffers Q16.16 samples as saturated PCM and plays them as an I2S master (bus.slave carries stream, I2S lines, flags, level)
module audio_output_serializer import audio_output_serializer_pkg::*; #(
  parameter int g_fifoDepth = 8,
  parameter int g_bclkDiv = 4
) (
  input logic i_clk,
  input logic i_reset,
  audio_output_serializer_if.slave bus
);
  localparam int DW = $clog2(g_bclkDiv) > 0 ? $clog2(g_bclkDiv) : 1;
  localparam int LW = $clog2(g_fifoDepth) + 1;
  logic [DW-1:0] div_q;
  logic [4:0] slot_q, slot_d;
  logic [c_pcmwidth-1:0] word_q, head;
  logic [LW-1:0] level;
  logic [3:0] bit_idx;
  logic bclk_q, lrclk_q, sdata_q, ovf_q, unf_q;
  logic wrap, fall, frame, full, empty, pop, push, ovf_ev, unf_ev;
  always_comb begin
    wrap = div_q == DW'(g_bclkDiv - 1);
    fall = wrap && bclk_q;
    slot_d = slot_q + 5'd1;
    frame = fall && slot_q == 5'(c_i2sslots - 1);
    pop = frame && !empty;
    unf_ev = frame && empty;
    push = bus.sample_valid && (!full || pop);
    ovf_ev = bus.sample_valid && full && !pop;
    bit_idx = 4'(5'd16 - slot_d);
  end
  audio_output_serializer_sample_fifo #(.DEPTH(g_fifoDepth), .WIDTH(c_pcmwidth)) u_fifo (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .push_i(push),
    .pop_i(pop),
    .data_i(saturate_to_pcm(bus.sample)),
    .data_o(head),
    .full_o(full),
    .empty_o(empty),
    .level_o(level)
  );
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      div_q <= '0;
      bclk_q <= 1'b0;
      slot_q <= '0;
      lrclk_q <= 1'b0;
      sdata_q <= 1'b0;
      word_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      div_q <= wrap ? '0 : div_q + 1'b1;
      bclk_q <= bclk_q ^ wrap;
      if (fall) begin
        slot_q <= slot_d;
        lrclk_q <= slot_d[4];
        sdata_q <= word_q[bit_idx];
      end
      if (pop) word_q <= head;
      ovf_q <= ovf_ev || (ovf_q && !bus.clear_flags);
      unf_q <= unf_ev || (unf_q && !bus.clear_flags);
    end
  end
  assign bus.bclk = bclk_q;
  assign bus.lrclk = lrclk_q;
  assign bus.sdata = sdata_q;
  assign bus.overflow = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.fifo_level = level;
endmodule

// File: tb/tb_audio_output_serializer.sv
// tb_audio_output_serializer: time-based I2S framing model with a queue-backed FIFO reference
module tb_audio_output_serializer;
  localparam int DIV = 2;
  localparam int DEPTH = 8;
  localparam int FRAME = 2 * DIV * 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int n = 0;
  logic [15:0] q[$];
  logic [15:0] w = '0;
  logic sd = 1'b0;
  logic m_ovf = 1'b0;
  logic m_unf = 1'b0;
  audio_output_serializer_if #(.FIFO_DEPTH(DEPTH)) bus ();
  audio_output_serializer #(.g_fifoDepth(DEPTH), .g_bclkDiv(DIV)) dut (
    .i_clk(clk),
    .i_reset(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] pcm(input logic [31:0] s);
    longint h;
    h = longint'($signed(s)) >>> 1;
    return h > 32767 ? 16'h7fff : h < -32768 ? 16'h8000 : 16'(h);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic v, input logic [31:0] s, input logic clr, input logic r);
    logic ovf_ev, unf_ev;
    int slot;
    bus.sample_valid = v;
    bus.sample = s;
    bus.clear_flags = clr;
    rst = r;
    @(posedge clk);
    #1;
    ovf_ev = 1'b0;
    unf_ev = 1'b0;
    if (r) begin
      n = 0;
      q.delete();
      w = '0;
      sd = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      n++;
      if (n % (2 * DIV) == 0) begin
        slot = (n / (2 * DIV)) % 32;
        if (slot == 0) begin
          sd = w[0];
          if (q.size() > 0) w = q.pop_front();
          else unf_ev = 1'b1;
        end else sd = w[(16 - slot) % 16];
      end
      if (v) begin
        if (q.size() < DEPTH) q.push_back(pcm(s));
        else ovf_ev = 1'b1;
      end
      m_ovf = ovf_ev || (m_ovf && !clr);
      m_unf = unf_ev || (m_unf && !clr);
    end
    chk("bclk", 32'(bus.bclk), 32'((n / DIV) % 2));
    chk("lrclk", 32'(bus.lrclk), 32'(((n / (2 * DIV)) % 32) >= 16));
    chk("sdata", 32'(bus.sdata), 32'(sd));
    chk("level", 32'(bus.fifo_level), 32'(q.size()));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("underflow", 32'(bus.underflow), 32'(m_unf));
  endtask
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1'b0, '0, 1'b0, 1'b0);
  endtask
  initial begin
    logic [31:0] sat_vals [6];
    sat_vals = '{32'h00020000, 32'hFFFE0000, 32'hFFFFFFFF, 32'h00010000, 32'hFFFF0000, 32'h00008000};
    bus.sample_valid = 1'b0;
    bus.sample = '0;
    bus.clear_flags = 1'b0;
    repeat (3) cyc(1'b0, '0, 1'b0, 1'b1);
    chk("reset_level", 32'(bus.fifo_level), 32'd0);
    idle(300);
    chk("idle_underflow", 32'(bus.underflow), 32'd1);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("clear_underflow", 32'(bus.underflow), 32'd0);
    while (n % FRAME != 1) idle(1);
    cyc(1'b1, 32'h00008000, 1'b0, 1'b0);
    chk("single_level", 32'(bus.fifo_level), 32'd1);
    idle(2 * FRAME);
    foreach (sat_vals[i]) begin
      while (n % FRAME != 1) idle(1);
      cyc(1'b1, sat_vals[i], 1'b0, 1'b0);
    end
    idle(2 * FRAME);
    cyc(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) cyc(1'b1, 32'((i + 1) * 32'h00001234), 1'b0, 1'b0);
    chk("full_level", 32'(bus.fifo_level), 32'd8);
    chk("full_overflow", 32'(bus.overflow), 32'd1);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("clear_overflow", 32'(bus.overflow), 32'd0);
    while ((n + 1) % FRAME != 0) idle(1);
    cyc(1'b1, 32'hFFFF9000, 1'b0, 1'b0);
    chk("pop_push_level", 32'(bus.fifo_level), 32'd8);
    chk("pop_push_no_ovf", 32'(bus.overflow), 32'd0);
    idle(10 * FRAME);
    chk("drain_level", 32'(bus.fifo_level), 32'd0);
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 39) == 0,
          $urandom_range(0, 3) == 0 ? 32'($urandom) : 32'($signed(17'($urandom))),
          $urandom_range(0, 63) == 0, 1'b0);
    while (((n / (2 * DIV)) % 32) != 20) idle(1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("midreset_bclk", 32'(bus.bclk), 32'd0);
    chk("midreset_lrclk", 32'(bus.lrclk), 32'd0);
    chk("midreset_sdata", 32'(bus.sdata), 32'd0);
    chk("midreset_level", 32'(bus.fifo_level), 32'd0);
    idle(300);
    chk("restart_underflow", 32'(bus.underflow), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/audio_output_serializer.md
Name: audio_output_serializer

Overview:
- Downstream consumer of processingGrid: accepts the `o_outputReady`/`o_output` sample stream (signed Q16.16, `c_datawidth` bits).
- Buffers samples in a small FIFO and converts each one to saturated 16-bit PCM.
- Serialises samples as an I2S master (bit clock, word clock, data) for an external DAC.
- Decouples the bursty, grid-timed sample production from the fixed audio frame rate.

Parameters:
g_fifoDepth, 8, FIFO entries; power of two, at least 2
g_bclkDiv, 4, i_clk cycles per half bit-clock period; at least 1

Ports:
i_clk  in  1  system clock; all logic on rising edge
i_reset  in  1  synchronous, active-high reset
i_sampleValid  in  1  one-cycle strobe, driven from processingGrid o_outputReady
i_sample  in  c_datawidth  signed Q16.16 sample, driven from o_output
i_clearFlags  in  1  clears the sticky flags
o_bclk  out  1  I2S bit clock
o_lrclk  out  1  I2S word select; 0 = left, 1 = right
o_sdata  out  1  I2S serial data
o_overflow  out  1  sticky: a sample was dropped because the FIFO was full
o_underflow  out  1  sticky: a frame started with the FIFO empty
o_fifoLevel  out  $clog2(g_fifoDepth)+1  current FIFO occupancy

Behaviour:
- Reset (synchronous, wins over everything):
  - all outputs 0; FIFO emptied; divider, slot counter and word register (`r_word`) = 0.
  - Applies equally mid-frame.
- Conversion, applied at FIFO write so the FIFO stores 16-bit words:
  - pcm = i_sample >>> 1 (arithmetic shift).
  - Saturate to [-32768, 32767]: Q16.16 value 1.0 (0x00010000) maps to 0x7FFF; -1.0 maps to 0x8000.
- FIFO write:
  - i_sampleValid=1 and not full: write; level increments.
  - Full and no pop in the same cycle: sample dropped, o_overflow set.
  - Full with a pop in the same cycle: write accepted, level unchanged.
- Divider:
  - Counter runs 0..g_bclkDiv-1; o_bclk toggles in the cycle the counter wraps.
  - First o_bclk rising edge occurs g_bclkDiv cycles after reset release.
  - Bit-clock period is 2*g_bclkDiv cycles.
- Slot counter:
  - Runs 0..31 and advances on each o_bclk falling edge (the 1→0 toggle cycle).
  - o_lrclk is 0 for slots 0..15 and 1 for slots 16..31.
- Frame start (slot counter 31→0 transition):
  - FIFO not empty: pop one word into `r_word`.
  - FIFO empty: `r_word` holds its previous value and o_underflow is set.
  - No pop occurs before the first 31→0 transition.
- Serial data:
  - Updated on the same falling-edge cycle as the slot counter.
  - In slot s, o_sdata = r_word[(16 - s) mod 16].
  - This gives MSB in slots 1 and 17 (one-bit I2S delay) and LSB in slots 16 and 0.
  - The same mono word is sent on both channels.
  - Slot 0 carries bit 0 of the word that was current before the pop.
- Sticky flags:
  - Cleared when i_clearFlags=1, unless a new event occurs in the same cycle; the event wins.
  - Cleared only by i_clearFlags or reset.
- o_fifoLevel is registered and reflects the state after each cycle's push and pop.
- No combinational path from inputs to outputs.

Decomposition:
- Additions to pkg_audiovhd:
  - constant c_pcmwidth = 16
  - constant c_i2sslots = 32
  - function saturateToPcm (Q16.16 to signed 16)
- One natural sub-module: sample_fifo.
  - Synchronous FIFO: depth/width parameters, push/pop, full/empty/level.
  - Behaviour on simultaneous push and pop when full as defined above.
- Divider, slot counter and shifter stay in the top level.

Test Plan (all with g_bclkDiv=2, so one bit = 4 cycles and one frame = 128 cycles):
- Reset then idle 300 cycles:
  - o_bclk first rises 2 cycles after reset release.
  - o_lrclk period is 128 cycles.
  - o_sdata stays 0; o_underflow = 1 after the first frame boundary.
- Push 0x00008000 once:
  - after the next frame boundary, slots 1..16 and 17..31,0 carry 0x4000 MSB-first.
  - o_fifoLevel goes 1 then 0.
- Push 0x00020000, 0xFFFE0000, 0xFFFFFFFF on consecutive frames:
  - serialised words are 0x7FFF, 0x8000, 0xFFFF.
- Push 9 samples back-to-back at reset release:
  - o_fifoLevel = 8 and o_overflow = 1.
  - After 8 frames the popped words are the first 8 samples; the 9th never appears.
- Hold FIFO full, then push in the exact pop cycle:
  - push accepted, level stays 8, no overflow.
  - Pulse i_clearFlags: flags read 0 the next cycle.
- Assert i_reset at slot 20 mid-frame:
  - next cycle all outputs are 0 and o_fifoLevel = 0.
  - Framing restarts from slot 0 identically to the first scenario.
